// File: rtl/spi_exe_master_pkg.sv
// Frame geometry and FSM encoding shared by the SPI execute master and its bench.
package spi_exe_master_pkg;

  localparam int OPER_W  = 4;
  localparam int ARG_W   = 8;
  localparam int RES_W   = 8;
  localparam int FLAG_W  = 4;
  localparam int TX_BITS = OPER_W + 2 * ARG_W;
  localparam int RX_BITS = RES_W + FLAG_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_TX,
    S_GAP,
    S_RX,
    S_FINISH
  } state_t;

  typedef struct packed {
    state_t state;
    logic   sclk_rise;
  } dbg_t;

endpackage

// File: rtl/spi_exe_master_clk_gen.sv
// SCLK generator: toggles every CLK_DIV cycles while enabled, parks low otherwise.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;
  logic          tick;

  // Strobes fire in the cycle before the registered sclk edge they announce.
  assign tick = en && (cnt == CW'(CLK_DIV - 1));
  assign rise = tick && !sclk;
  assign fall = tick && sclk;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_exe_master.sv
// SPI master sending {oper,argA,argB}, waiting TURN periods, then reading {result,flags}.
module spi_exe_master
  import spi_exe_master_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int TURN    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [OPER_W-1:0] i_oper,
  input  logic [ARG_W-1:0]  i_argA,
  input  logic [ARG_W-1:0]  i_argB,
  output logic              o_busy,
  output logic              o_done,
  output logic [RES_W-1:0]  o_result,
  output logic [FLAG_W-1:0] o_flags,
  output logic              o_sclk,
  output logic              o_cs_n,
  output logic              o_mosi,
  input  logic              i_miso,
  output dbg_t              o_dbg
);

  // Handshake: i_start is taken only when IDLE and o_busy is low; o_busy stays
  // high through the o_done pulse and drops the cycle after it.

  localparam int CW  = $clog2(CLK_DIV + 1);
  localparam int PW0 = $clog2(TURN + 1);
  localparam int PW  = (PW0 > 5) ? PW0 : 5;

  state_t               state;
  logic [CW-1:0]        wait_cnt;
  logic [PW-1:0]        per_cnt;
  logic [TX_BITS-1:0]   tx_sr;
  logic [RX_BITS-1:0]   rx_sr;
  logic                 clk_en;
  logic                 sclk_rise;
  logic                 sclk_fall;

  assign clk_en = (state == S_TX) || (state == S_GAP) || (state == S_RX);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .en    (clk_en),
    .sclk  (o_sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // TX register drains to zero after 20 shifts, so MOSI idles low in GAP/RX.
  assign o_mosi = tx_sr[TX_BITS-1];
  assign o_dbg  = '{state: state, sclk_rise: sclk_rise};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      o_cs_n   <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
      o_flags  <= '0;
      wait_cnt <= '0;
      per_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else begin
      o_done <= 1'b0;
      if (o_done) o_busy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start && !o_busy) begin
            tx_sr    <= {i_oper, i_argA, i_argB};
            rx_sr    <= '0;
            o_cs_n   <= 1'b0;
            o_busy   <= 1'b1;
            wait_cnt <= '0;
            per_cnt  <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (wait_cnt == CW'(CLK_DIV - 1)) begin
            wait_cnt <= '0;
            state    <= S_TX;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_TX: begin
          if (sclk_fall) begin
            tx_sr <= tx_sr << 1;
            if (per_cnt == PW'(TX_BITS - 1)) begin
              per_cnt <= '0;
              state   <= S_GAP;
            end else begin
              per_cnt <= per_cnt + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (sclk_fall) begin
            if (per_cnt == PW'(TURN - 1)) begin
              per_cnt <= '0;
              state   <= S_RX;
            end else begin
              per_cnt <= per_cnt + 1'b1;
            end
          end
        end
        S_RX: begin
          if (sclk_fall) begin
            rx_sr <= {rx_sr[RX_BITS-2:0], i_miso};
            if (per_cnt == PW'(RX_BITS - 1)) begin
              per_cnt <= '0;
              o_cs_n  <= 1'b1;
              state   <= S_FINISH;
            end else begin
              per_cnt <= per_cnt + 1'b1;
            end
          end
        end
        S_FINISH: begin
          if (wait_cnt == CW'(CLK_DIV)) begin
            o_result <= rx_sr[RX_BITS-1:FLAG_W];
            o_flags  <= rx_sr[FLAG_W-1:0];
            o_done   <= 1'b1;
            wait_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_exe_master.sv
// Bench for spi_exe_master: slave models, queued expectations, default and fastest configs.
module tb_spi_exe_master;
  import spi_exe_master_pkg::*;

  localparam int DIV0  = 4;
  localparam int TURN0 = 2;
  localparam int LAT0  = (2 * (32 + TURN0) + 2) * DIV0 + 1;
  localparam int DIV1  = 1;
  localparam int TURN1 = 1;
  localparam int LAT1  = (2 * (32 + TURN1) + 2) * DIV1 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic i_rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 0 (defaults) ----------------
  logic       i_start, o_busy, o_done, o_sclk, o_cs_n, o_mosi, i_miso;
  logic [3:0] i_oper, o_flags;
  logic [7:0] i_argA, i_argB, o_result;
  dbg_t       dbg0;

  spi_exe_master #(.CLK_DIV(DIV0), .TURN(TURN0)) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_oper(i_oper),
    .i_argA(i_argA), .i_argB(i_argB), .o_busy(o_busy), .o_done(o_done),
    .o_result(o_result), .o_flags(o_flags), .o_sclk(o_sclk), .o_cs_n(o_cs_n),
    .o_mosi(o_mosi), .i_miso(i_miso), .o_dbg(dbg0)
  );

  // ---------------- DUT 1 (CLK_DIV=1, TURN=1) ----------------
  logic       f_start, f_busy, f_done, f_sclk, f_cs_n, f_mosi, f_miso;
  logic [3:0] f_oper, f_flags;
  logic [7:0] f_argA, f_argB, f_result;
  dbg_t       dbg1;

  spi_exe_master #(.CLK_DIV(DIV1), .TURN(TURN1)) u_dut_fast (
    .i_clk(clk), .i_rst(i_rst), .i_start(f_start), .i_oper(f_oper),
    .i_argA(f_argA), .i_argB(f_argB), .o_busy(f_busy), .o_done(f_done),
    .o_result(f_result), .o_flags(f_flags), .o_sclk(f_sclk), .o_cs_n(f_cs_n),
    .o_mosi(f_mosi), .i_miso(f_miso), .o_dbg(dbg1)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          done_cnt = 0;
  int          t0 = 0;
  logic [11:0] slave_resp = '0;
  logic [11:0] f_resp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slave models ----------------
  // Slave captures MOSI on its rising edges and drives MISO on rising edges of RX periods.
  int          rise_n = 0;
  logic [19:0] mosi_cap = '0;
  always @(negedge o_cs_n or posedge o_sclk) begin
    if (!o_sclk) begin
      rise_n   = 0;
      mosi_cap = '0;
    end else if (!o_cs_n) begin
      rise_n++;
      if (rise_n <= 20) mosi_cap = {mosi_cap[18:0], o_mosi};
      else if (rise_n > 20 + TURN0 && rise_n <= 32 + TURN0) i_miso = slave_resp[32 + TURN0 - rise_n];
      else i_miso = 1'($urandom);
    end
  end

  int          f_rise_n = 0;
  logic [19:0] f_mosi_cap = '0;
  always @(negedge f_cs_n or posedge f_sclk) begin
    if (!f_sclk) begin
      f_rise_n   = 0;
      f_mosi_cap = '0;
    end else if (!f_cs_n) begin
      f_rise_n++;
      if (f_rise_n <= 20) f_mosi_cap = {f_mosi_cap[18:0], f_mosi};
      else if (f_rise_n > 20 + TURN1 && f_rise_n <= 32 + TURN1) f_miso = f_resp[32 + TURN1 - f_rise_n];
      else f_miso = 1'($urandom);
    end
  end

  // ---------------- monitor ----------------
  logic [11:0] last_out = '0;
  logic        prev_cs = 1'b1;
  int          cs_run = 0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (i_rst) begin
      last_out = '0;
    end else if (o_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done_cnt), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("mosi_stream", 32'(mosi_cap), 32'(e[31:12]));
        chk("result", 32'(o_result), 32'(e[11:4]));
        chk("flags", 32'(o_flags), 32'(e[3:0]));
        chk("latency", 32'(cyc - t0), 32'(LAT0));
        chk("rise_count", 32'(rise_n), 32'(32 + TURN0));
        chk("busy_at_done", 32'(o_busy), 32'(1));
      end
      last_out = {o_result, o_flags};
    end else begin
      chk("outputs_hold", 32'({o_result, o_flags}), 32'(last_out));
    end
    if (o_cs_n) begin
      chk("sclk_idle", 32'(o_sclk), 32'(0));
      cs_run++;
    end else begin
      if (prev_cs && !i_rst) chk("cs_high_gap_ok", 32'(cs_run >= DIV0 + 1), 32'(1));
      cs_run = 0;
    end
    prev_cs = o_cs_n;
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [11:0] resp);
    int n = 0;
    @(negedge clk);
    while (o_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (o_busy) chk("busy_timeout", 32'(o_busy), 32'(0));
    slave_resp = resp;
    i_oper     = op;
    i_argA     = a;
    i_argB     = b;
    i_start    = 1'b1;
    exp_q.push_back({op, a, b, resp});
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done();
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == base) chk("done_timeout", 32'(done_cnt), 32'(base + 1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    int n;
    int ft0;
    i_rst = 1'b1;
    i_start = 0; i_oper = 0; i_argA = 0; i_argB = 0; i_miso = 0;
    f_start = 0; f_oper = 0; f_argA = 0; f_argB = 0; f_miso = 0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_cs_n", 32'(o_cs_n), 32'(1));
    chk("rst_sclk", 32'(o_sclk), 32'(0));
    chk("rst_mosi", 32'(o_mosi), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_done", 32'(o_done), 32'(0));
    chk("rst_outputs", 32'({o_result, o_flags}), 32'(0));

    // Directed frames
    start_frame(4'h1, 8'h05, 8'h03, {8'h08, 4'h0});
    wait_done();
    start_frame(4'h9, 8'hC3, 8'h5A, {8'hFF, 4'hA});
    wait_done();
    repeat (100) @(negedge clk);
    chk("hold_result", 32'(o_result), 32'(8'hFF));
    chk("hold_flags", 32'(o_flags), 32'(4'hA));

    // Random back-to-back frames
    for (int i = 0; i < 6; i++) begin
      start_frame(4'($urandom), 8'($urandom), 8'($urandom), 12'($urandom));
      wait_done();
    end

    // Start pulse mid-frame is ignored
    d0 = done_cnt;
    start_frame(4'($urandom), 8'($urandom), 8'($urandom), 12'($urandom));
    repeat (48) @(negedge clk);
    i_start = 1'b1;
    i_oper  = 4'($urandom);
    @(negedge clk);
    i_start = 1'b0;
    wait_done();
    repeat (300) @(negedge clk);
    chk("one_done_only", 32'(done_cnt - d0), 32'(1));
    chk("idle_after_ignore", 32'({o_busy, o_cs_n}), 32'(2'b01));

    // Start coincident with o_done is ignored
    start_frame(4'($urandom), 8'($urandom), 8'($urandom), 12'($urandom));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_done && n < 2000);
    chk("saw_done", 32'(o_done), 32'(1));
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("coincident_start_ignored", 32'({o_busy, o_cs_n}), 32'(2'b01));

    // Reset mid-frame aborts with no o_done
    start_frame(4'($urandom), 8'($urandom), 8'($urandom), 12'($urandom));
    while (cyc < t0 + 120) @(posedge clk);
    #2 i_rst = 1'b1;
    #1;
    chk("abort_cs_n", 32'(o_cs_n), 32'(1));
    chk("abort_sclk", 32'(o_sclk), 32'(0));
    chk("abort_busy", 32'(o_busy), 32'(0));
    chk("abort_mosi", 32'(o_mosi), 32'(0));
    void'(exp_q.pop_back());
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    i_rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("no_done_after_abort", 32'(done_cnt), 32'(d0));
    start_frame(4'($urandom), 8'($urandom), 8'($urandom), 12'($urandom));
    wait_done();
    chk("frame_after_abort", 32'(done_cnt), 32'(d0 + 1));

    // Fastest configuration
    f_resp = 12'($urandom);
    @(negedge clk);
    f_oper  = 4'($urandom);
    f_argA  = 8'($urandom);
    f_argB  = 8'($urandom);
    f_start = 1'b1;
    @(posedge clk);
    #1 ft0 = cyc;
    @(negedge clk);
    f_start = 1'b0;
    n = 0;
    while (!f_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("fast_done_seen", 32'(f_done), 32'(1));
    chk("fast_latency", 32'(cyc - ft0), 32'(LAT1));
    chk("fast_result", 32'(f_result), 32'(f_resp[11:4]));
    chk("fast_flags", 32'(f_flags), 32'(f_resp[3:0]));
    chk("fast_stream", 32'(f_mosi_cap), 32'({f_oper, f_argA, f_argB}));
    chk("fast_rise_count", 32'(f_rise_n), 32'(32 + TURN1));

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
